// File: rtl/bms_pkg.sv
// Shared encodings for the pack-mode controller: state values, fault_code bit positions
// and the hard-fault qualifier.
package bms_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEADTIME  = 3'd1,
    ST_PRECHARGE = 3'd2,
    ST_DISCHARGE = 3'd3,
    ST_CHARGE    = 3'd4,
    ST_FAULT     = 3'd5
  } bms_state_e;

  localparam int FC_OV = 0;
  localparam int FC_UV = 1;
  localparam int FC_OC = 2;
  localparam int FC_OT = 3;
  localparam int FC_W  = 4;

  function automatic logic is_hard_fault(input logic [FC_W-1:0] q);
    return q[FC_OC] | q[FC_OT];
  endfunction

endpackage

// File: rtl/bms_mode_fsm_if.sv
// Bundle between the pack-mode controller (master) and its comparator/host/gate-driver neighbours (slave).
interface bms_mode_fsm_if;
  import bms_pkg::*;

  logic       ov_flag;
  logic       uv_flag;
  logic       oc_flag;
  logic       ot_flag;
  logic       charger_present;
  logic       load_request;
  logic       fault_clear;
  logic       charge_en_fsm;
  logic       discharge_en_fsm;
  logic       precharge_en;
  logic       system_fault;
  logic [3:0] fault_code;
  bms_state_e bms_state;

  modport master (
    input  ov_flag, uv_flag, oc_flag, ot_flag,
    input  charger_present, load_request, fault_clear,
    output charge_en_fsm, discharge_en_fsm, precharge_en, system_fault,
    output fault_code, bms_state
  );

  modport slave (
    output ov_flag, uv_flag, oc_flag, ot_flag,
    output charger_present, load_request, fault_clear,
    input  charge_en_fsm, discharge_en_fsm, precharge_en, system_fault,
    input  fault_code, bms_state
  );

endinterface

// File: rtl/bms_debounce.sv
// Flag qualifier: q follows raw after DEBOUNCE_CYCLES consecutive samples at the new level.
// rise is high for the first cycle q reads 1.
module bms_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic q,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      q    <= 1'b0;
      rise <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (raw == q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        q    <= raw;
        rise <= raw;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bms_mode_fsm.sv
// Pack-mode controller: debounced protection flags, charger/load arbitration, deadtime-separated enables.
// Enables follow the state register; BMS_PRECHARGE_EN inserts PRECHARGE ahead of DISCHARGE.
module bms_mode_fsm
  import bms_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int DEADTIME_CYCLES  = 8,
  parameter int PRECHARGE_CYCLES = 1000
) (
  input logic            clk,
  input logic            rst_n,
  bms_mode_fsm_if.master bus
);

  localparam int CNT_MAX = (DEADTIME_CYCLES > PRECHARGE_CYCLES) ? DEADTIME_CYCLES : PRECHARGE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DEADTIME_CYCLES - 1);
`ifdef BMS_PRECHARGE_EN
  localparam logic [CNT_W-1:0] PC_LAST = CNT_W'(PRECHARGE_CYCLES - 1);
`endif

  logic [FC_W-1:0] raw_vec;
  logic [FC_W-1:0] q_vec;
  logic [FC_W-1:0] rise_vec;

  assign raw_vec = {bus.ot_flag, bus.oc_flag, bus.uv_flag, bus.ov_flag};

  for (genvar i = 0; i < FC_W; i++) begin : g_db
    bms_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_vec[i]),
      .q    (q_vec[i]),
      .rise (rise_vec[i])
    );
  end

  bms_state_e       state;
  bms_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             tgt_chg;
  logic             tgt_chg_nxt;
  logic             clear_ok;
  logic             chg_drop;
  logic             dsg_req_drop;
  logic             dsg_drop;
  logic             charge_en_q;
  logic             discharge_en_q;
  logic             system_fault_q;
  logic [FC_W-1:0]  fault_code_q;

  // A live charger always pre-empts discharge so that path switches re-arbitrate in IDLE.
  assign chg_drop     = !bus.charger_present | q_vec[FC_OV];
  assign dsg_req_drop = !bus.load_request | q_vec[FC_UV];
  assign dsg_drop     = dsg_req_drop | bus.charger_present;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    tgt_chg_nxt = tgt_chg;
    clear_ok    = 1'b0;
    if (is_hard_fault(q_vec)) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!chg_drop) begin
            state_nxt   = ST_DEADTIME;
            tgt_chg_nxt = 1'b1;
          end else if (!dsg_req_drop) begin
            state_nxt   = ST_DEADTIME;
            tgt_chg_nxt = 1'b0;
          end
        end
        ST_DEADTIME: begin
          if (tgt_chg ? chg_drop : dsg_req_drop) begin
            state_nxt = ST_IDLE;
          end else if (cnt == DT_LAST) begin
            if (tgt_chg) state_nxt = ST_CHARGE;
`ifdef BMS_PRECHARGE_EN
            else         state_nxt = ST_PRECHARGE;
`else
            else         state_nxt = ST_DISCHARGE;
`endif
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
`ifdef BMS_PRECHARGE_EN
        ST_PRECHARGE: begin
          if (dsg_drop)              state_nxt = ST_IDLE;
          else if (cnt == PC_LAST)   state_nxt = ST_DISCHARGE;
          else                       cnt_nxt   = cnt + CNT_W'(1);
        end
`endif
        ST_DISCHARGE: if (dsg_drop) state_nxt = ST_IDLE;
        ST_CHARGE:    if (chg_drop) state_nxt = ST_IDLE;
        ST_FAULT: begin
          if (bus.fault_clear) begin
            state_nxt = ST_IDLE;
            clear_ok  = 1'b1;
          end
        end
        default: state_nxt = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      tgt_chg        <= 1'b0;
      charge_en_q    <= 1'b0;
      discharge_en_q <= 1'b0;
      system_fault_q <= 1'b0;
      fault_code_q   <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      tgt_chg        <= tgt_chg_nxt;
      charge_en_q    <= (state_nxt == ST_CHARGE);
      discharge_en_q <= (state_nxt == ST_DISCHARGE);
      system_fault_q <= (state_nxt == ST_FAULT);
      // A flag qualifying in the same cycle as an accepted clear survives the clear.
      fault_code_q   <= clear_ok ? rise_vec : (fault_code_q | rise_vec);
    end
  end

`ifdef BMS_PRECHARGE_EN
  logic precharge_en_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) precharge_en_q <= 1'b0;
    else        precharge_en_q <= (state_nxt == ST_PRECHARGE);
  end
  assign bus.precharge_en = precharge_en_q;
`else
  assign bus.precharge_en = 1'b0;
`endif

  assign bus.charge_en_fsm    = charge_en_q;
  assign bus.discharge_en_fsm = discharge_en_q;
  assign bus.system_fault     = system_fault_q;
  assign bus.fault_code       = fault_code_q;
  assign bus.bms_state        = state;

endmodule

// File: tb/tb_bms_mode_fsm.sv
// Bench for bms_mode_fsm: directed vector table, corner-case sequences, then random stimulus
// checked every cycle against a deadline-based behavioural model.
module tb_bms_mode_fsm;
  import bms_pkg::*;

  localparam int DB = 4;
  localparam int DT = 3;
  localparam int PC = 10;
`ifdef BMS_PRECHARGE_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif
  localparam int PC_EFF = PC_EN ? PC : 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bms_mode_fsm_if bus_if ();

  bms_mode_fsm #(
    .DEBOUNCE_CYCLES (DB),
    .DEADTIME_CYCLES (DT),
    .PRECHARGE_CYCLES(PC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  // Reference model: qualified flags via run lengths, timed phases via absolute deadlines.
  bms_state_e m_st;
  bit         m_tgt_chg;
  int         m_end;
  int         cyc;
  bit [3:0]   mq;
  bit [3:0]   mqp;
  bit [3:0]   mfc;
  int         run [4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = ST_IDLE; m_tgt_chg = 1'b0; m_end = 0; cyc = 0;
    mq = '0; mqp = '0; mfc = '0;
    for (int i = 0; i < 4; i++) run[i] = 0;
  endtask

  task automatic model_edge();
    bit [3:0]   raw, rises;
    bit         chg, load, clr, hard;
    bms_state_e ns;
    raw  = {bus_if.ot_flag, bus_if.oc_flag, bus_if.uv_flag, bus_if.ov_flag};
    chg  = bus_if.charger_present;
    load = bus_if.load_request;
    clr  = bus_if.fault_clear;
    cyc++;
    hard  = mq[FC_OC] | mq[FC_OT];
    rises = mq & ~mqp;
    ns    = m_st;
    if (hard) ns = ST_FAULT;
    else begin
      case (m_st)
        ST_IDLE:
          if (chg && !mq[FC_OV])       begin ns = ST_DEADTIME; m_tgt_chg = 1'b1; m_end = cyc + DT; end
          else if (load && !mq[FC_UV]) begin ns = ST_DEADTIME; m_tgt_chg = 1'b0; m_end = cyc + DT; end
        ST_DEADTIME:
          if (m_tgt_chg ? (!chg || mq[FC_OV]) : (!load || mq[FC_UV])) ns = ST_IDLE;
          else if (cyc == m_end) begin
            if (m_tgt_chg) ns = ST_CHARGE;
            else if (PC_EN) begin ns = ST_PRECHARGE; m_end = cyc + PC; end
            else ns = ST_DISCHARGE;
          end
        ST_PRECHARGE:
          if (!load || mq[FC_UV] || chg) ns = ST_IDLE;
          else if (cyc == m_end)         ns = ST_DISCHARGE;
        ST_DISCHARGE: if (!load || mq[FC_UV] || chg) ns = ST_IDLE;
        ST_CHARGE:    if (!chg || mq[FC_OV])         ns = ST_IDLE;
        ST_FAULT:     if (clr) begin ns = ST_IDLE; mfc = '0; end
        default: ;
      endcase
    end
    mfc  = mfc | rises;
    m_st = ns;
    mqp  = mq;
    for (int i = 0; i < 4; i++) begin
      if (raw[i] != mq[i]) begin
        run[i]++;
        if (run[i] == DB) begin mq[i] = raw[i]; run[i] = 0; end
      end else run[i] = 0;
    end
  endtask

  task automatic tick();
    logic [10:0] act, exp;
    logic        bad;
    @(posedge clk);
    model_edge();
    #1;
    act = {bus_if.bms_state, bus_if.charge_en_fsm, bus_if.discharge_en_fsm,
           bus_if.precharge_en, bus_if.system_fault, bus_if.fault_code};
    exp = {m_st, m_st == ST_CHARGE, m_st == ST_DISCHARGE,
           PC_EN && (m_st == ST_PRECHARGE), m_st == ST_FAULT, mfc};
    check("model {state,ce,de,pe,sf,fc}", int'(act), int'(exp));
    bad = (bus_if.charge_en_fsm & bus_if.discharge_en_fsm) |
          ((bus_if.charge_en_fsm | bus_if.discharge_en_fsm | bus_if.precharge_en) & bus_if.system_fault);
    check("enable exclusivity", int'(bad), 0);
  endtask

  task automatic drive(input bit chg, input bit load, input bit [3:0] flags, input bit clr);
    bus_if.charger_present = chg;
    bus_if.load_request    = load;
    {bus_if.ot_flag, bus_if.oc_flag, bus_if.uv_flag, bus_if.ov_flag} = flags;
    bus_if.fault_clear     = clr;
  endtask

  function automatic int outs_now();
    return int'({bus_if.bms_state, bus_if.charge_en_fsm, bus_if.discharge_en_fsm,
                 bus_if.precharge_en, bus_if.system_fault, bus_if.fault_code});
  endfunction

  typedef struct {
    bit         chg;
    bit         load;
    bit [3:0]   flags;
    bit         clr;
    bms_state_e st;
    bit [3:0]   en;   // {charge, discharge, precharge, fault}
  } vec_t;

  function automatic vec_t mk(bit chg, bit load, bit [3:0] flags, bit clr, bms_state_e st, bit [3:0] en);
    vec_t v;
    v.chg = chg; v.load = load; v.flags = flags; v.clr = clr; v.st = st; v.en = en;
    return v;
  endfunction

  vec_t     vecs [18];
  int       n, npre;
  bit [3:0] rflags;
  bit       rchg, rload;

  initial begin
    vecs[0]  = mk(1, 0, 4'b0000, 0, ST_DEADTIME, 4'b0000);
    vecs[1]  = mk(1, 0, 4'b0000, 0, ST_DEADTIME, 4'b0000);
    vecs[2]  = mk(1, 0, 4'b0000, 0, ST_DEADTIME, 4'b0000);
    vecs[3]  = mk(1, 0, 4'b0000, 0, ST_CHARGE,   4'b1000);
    vecs[4]  = mk(1, 0, 4'b0000, 0, ST_CHARGE,   4'b1000);
    vecs[5]  = mk(0, 0, 4'b0000, 0, ST_IDLE,     4'b0000);
    vecs[6]  = mk(1, 1, 4'b0000, 0, ST_DEADTIME, 4'b0000);
    vecs[7]  = mk(1, 1, 4'b0000, 0, ST_DEADTIME, 4'b0000);
    vecs[8]  = mk(1, 1, 4'b0000, 0, ST_DEADTIME, 4'b0000);
    vecs[9]  = mk(1, 1, 4'b0000, 0, ST_CHARGE,   4'b1000);
    vecs[10] = mk(0, 1, 4'b0000, 0, ST_IDLE,     4'b0000);
    vecs[11] = mk(0, 1, 4'b0000, 0, ST_DEADTIME, 4'b0000);
    vecs[12] = mk(0, 0, 4'b0000, 0, ST_IDLE,     4'b0000);
    vecs[13] = mk(0, 0, 4'b0100, 0, ST_IDLE,     4'b0000);
    vecs[14] = mk(0, 0, 4'b0100, 0, ST_IDLE,     4'b0000);
    vecs[15] = mk(0, 0, 4'b0100, 0, ST_IDLE,     4'b0000);
    vecs[16] = mk(0, 0, 4'b0000, 0, ST_IDLE,     4'b0000);
    vecs[17] = mk(0, 0, 4'b0000, 0, ST_IDLE,     4'b0000);

    drive(0, 0, 4'b0000, 0);
    model_reset();
    #1 rst_n = 1'b0;
    #2 check("reset outputs", outs_now(), 0);
    #9 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].chg, vecs[i].load, vecs[i].flags, vecs[i].clr);
      tick();
      check($sformatf("vec%0d state", i), int'(bus_if.bms_state), int'(vecs[i].st));
      check($sformatf("vec%0d enables", i),
            int'({bus_if.charge_en_fsm, bus_if.discharge_en_fsm, bus_if.precharge_en, bus_if.system_fault}),
            int'(vecs[i].en));
    end

    // Discharge path timing and precharge width.
    drive(0, 1, 4'b0000, 0);
    n = 0; npre = 0;
    while (!bus_if.discharge_en_fsm && n < 60) begin
      tick(); n++;
      if (bus_if.precharge_en) npre++;
    end
    check("discharge latency", n, DT + 1 + PC_EFF);
    check("precharge cycles", npre, PC_EFF);
    check("precharge off with discharge", int'(bus_if.precharge_en), 0);

    // Over-current qualified during DISCHARGE.
    drive(0, 1, 4'b0100, 0);
    repeat (DB) tick();
    check("oc pending still discharging", int'(bus_if.bms_state), int'(ST_DISCHARGE));
    tick();
    check("oc fault state", int'(bus_if.bms_state), int'(ST_FAULT));
    check("oc fault discharge off", int'(bus_if.discharge_en_fsm), 0);
    check("oc fault code", int'(bus_if.fault_code), 4'b0100);

    // Clear refused while oc still qualified, accepted once it drops.
    drive(0, 1, 4'b0100, 1);
    tick();
    check("clear ignored state", int'(bus_if.bms_state), int'(ST_FAULT));
    check("clear ignored code", int'(bus_if.fault_code), 4'b0100);
    drive(0, 1, 4'b0000, 0);
    repeat (DB) tick();
    drive(0, 1, 4'b0000, 1);
    tick();
    drive(0, 1, 4'b0000, 0);
    check("clear accepted state", int'(bus_if.bms_state), int'(ST_IDLE));
    check("clear accepted code", int'(bus_if.fault_code), 0);

    // Charger arriving during DISCHARGE re-arbitrates through IDLE and a full deadtime.
    n = 0;
    while (!bus_if.discharge_en_fsm && n < 60) begin tick(); n++; end
    check("re-enter discharge", int'(bus_if.discharge_en_fsm), 1);
    drive(1, 1, 4'b0000, 0);
    tick();
    check("charger preempts to idle", int'(bus_if.bms_state), int'(ST_IDLE));
    n = 0;
    while (!bus_if.charge_en_fsm && n < 20) begin tick(); n++; end
    check("switch to charge latency", n, DT + 1);
    check("switch discharge off", int'(bus_if.discharge_en_fsm), 0);

    // Asynchronous reset part-way through the discharge sequence.
    drive(0, 1, 4'b0000, 0);
    tick();
    n = 0;
    while (!(bus_if.precharge_en || bus_if.discharge_en_fsm) && n < 40) begin tick(); n++; end
    tick(); tick();
    #2 rst_n = 1'b0;
    #1 check("async reset outputs", outs_now(), 0);
    model_reset();
    #2 rst_n = 1'b1;
    n = 0;
    while (!(bus_if.discharge_en_fsm || bus_if.charge_en_fsm) && n < 60) begin tick(); n++; end
    check("restart latency", n, DT + 1 + PC_EFF);

    // Random phase against the model.
    rflags = '0; rchg = 1'b0; rload = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      for (int f = 0; f < 4; f++) begin
        if (rflags[f]) begin
          if ($urandom_range(0, 5) == 0) rflags[f] = 1'b0;
        end else if ($urandom_range(0, (f >= 2) ? 80 : 25) == 0) rflags[f] = 1'b1;
      end
      if ($urandom_range(0, 24) == 0) rchg  = ~rchg;
      if ($urandom_range(0, 24) == 0) rload = ~rload;
      drive(rchg, rload, rflags, $urandom_range(0, 9) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
